// File: rtl/uart_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader_pkg
// Description : Shared constants and types for the UART boot loader: the frame
//               magic byte, loader/receiver state encodings and the baud
//               divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_boot_loader_pkg;

    // First byte of every boot frame.
    localparam logic [7:0] c_MAGIC = 8'hB5;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_LO     = 3'd1,
        ST_LEN_HI     = 3'd2,
        ST_DATA       = 3'd3,
        ST_DONE       = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // System clocks per UART bit (integer division).
    function automatic int clks_per_bit(input int clock_freq, input int bit_rate);
        return clock_freq / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver. Synchronises rx through two flops, detects
//               the start edge, re-checks the start bit at half a bit period
//               and samples data/stop bits at their midpoints.
// Ports       : clk, reset     - system clock, synchronous active-high reset
//               rx             - asynchronous serial input, idle high
//               data[7:0]      - last received byte (valid with 'valid')
//               valid          - 1-cycle pulse, good byte received
//               frame_err      - 1-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam logic [15:0] c_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;
    logic        w_fall;
    logic        w_hit;

    assign w_fall = r_prev & ~r_sync2;

    // Sample point for the current state.
    always_comb begin
        w_hit = 1'b0;
        unique case (r_state)
            RX_START:         w_hit = (r_cnt == c_HALF);
            RX_DATA, RX_STOP: w_hit = (r_cnt == c_FULL);
            default:          w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RX_IDLE:  if (w_fall) w_next = RX_START;
            // A start bit that is high again at mid-bit was a glitch.
            RX_START: if (w_hit) w_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_hit && (r_bit_idx == 3'd7)) w_next = RX_STOP;
            // Return to idle at the stop midpoint so a back-to-back start edge
            // half a bit later is caught.
            RX_STOP:  if (w_hit) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_next;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;

            if ((r_state == RX_IDLE) || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_state == RX_IDLE) begin
                r_bit_idx <= '0;
            end

            if (w_hit && (r_state == RX_DATA)) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_hit && (r_state == RX_STOP)) begin
                r_valid <= r_sync2;
                r_ferr  <= ~r_sync2;
            end
        end
    end

    assign data      = r_shift;
    assign valid     = r_valid;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader
// Description : Receives a framed program image over UART (magic 0xB5, 16-bit
//               LE word count, LE data words), writes it to memory one word at
//               a time and holds the CPU in reset until the image is loaded.
// Ports       : clk, reset     - system clock, synchronous active-high reset
//               rx             - asynchronous UART receive line
//               mem_we         - 1-cycle word write strobe
//               mem_addr       - word address of the write
//               mem_wdata      - write data
//               cpu_reset_o    - CPU reset, released once loading is done
//               busy           - frame in progress (length or data phase)
//               error          - sticky framing/length/timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLOCK_FREQ     = 25000000,
    parameter int BIT_RATE       = 115200,
    parameter int MEMORY_SIZE    = 4096,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx,
    output logic                           mem_we,
    output logic [$clog2(MEMORY_SIZE)-1:0] mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           cpu_reset_o,
    output logic                           busy,
    output logic                           error
);

    localparam int          c_CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BIT_RATE);
    localparam int          c_ADDR_W       = $clog2(MEMORY_SIZE);
    localparam logic [31:0] c_TIMEOUT      = 32'(TIMEOUT_CYCLES);

    logic [7:0]          w_rx_data;
    logic                w_rx_valid;
    logic                w_rx_ferr;

    loader_state_t       r_state;
    loader_state_t       w_next;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [15:0]         r_word_cnt;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_word;
    logic [c_ADDR_W-1:0] r_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic                r_cpu_reset;
    logic                r_error;
    logic [31:0]         r_timer;

    logic [15:0]         w_len;
    logic                w_busy;
    logic                w_timeout;
    logic                w_abort;
    logic                w_len_err;
    logic                w_write;

    uart_rx_byte #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (w_rx_data),
        .valid     (w_rx_valid),
        .frame_err (w_rx_ferr)
    );

    assign w_len     = {w_rx_data, r_len_lo};
    assign w_busy    = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA);
    assign w_timeout = w_busy && (r_timer == c_TIMEOUT);

    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_len_err = 1'b0;
        w_write   = 1'b0;
        unique case (r_state)
            ST_WAIT_MAGIC: begin
                if (w_rx_valid && (w_rx_data == c_MAGIC)) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_timeout || w_rx_ferr) w_abort = 1'b1;
                else if (w_rx_valid)        w_next  = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_timeout || w_rx_ferr) begin
                    w_abort = 1'b1;
                end else if (w_rx_valid) begin
                    if (w_len == 16'd0) begin
                        w_next = ST_DONE;
                    end else if (32'(w_len) > 32'(MEMORY_SIZE)) begin
                        w_len_err = 1'b1;
                        w_next    = ST_WAIT_MAGIC;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Timeout takes priority over a byte landing in the same cycle.
                if (w_timeout || w_rx_ferr) begin
                    w_abort = 1'b1;
                end else if (w_rx_valid && (r_byte_idx == 2'd3)) begin
                    w_write = 1'b1;
                    if (r_word_cnt == 16'(r_len - 16'd1)) w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_WAIT_MAGIC;
        endcase
        if (w_abort) w_next = ST_WAIT_MAGIC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_WAIT_MAGIC;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_error     <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_next;
            r_we        <= w_write;
            // Registered from the current state so the release happens one
            // cycle after the final write and never glitches.
            r_cpu_reset <= (r_state != ST_DONE);

            if (w_abort || w_len_err ||
                (w_rx_ferr && (r_state == ST_WAIT_MAGIC))) begin
                r_error <= 1'b1;
            end

            if (!w_busy || w_timeout || w_rx_valid) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            if (w_write) begin
                r_wdata <= {w_rx_data, r_word};
            end

            if (w_abort) begin
                r_byte_idx <= '0;
                r_word_cnt <= '0;
                r_addr     <= '0;
                r_len      <= '0;
            end else begin
                if (r_we) begin
                    r_addr <= r_addr + 1'b1;
                end
                if (w_rx_valid) begin
                    unique case (r_state)
                        ST_LEN_LO: r_len_lo <= w_rx_data;
                        ST_LEN_HI: r_len    <= w_len;
                        ST_DATA: begin
                            // Three shifts leave bytes 0..2 in [23:0]; the
                            // fourth byte is merged directly into the write.
                            r_word     <= {w_rx_data, r_word[23:8]};
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (r_byte_idx == 2'd3) begin
                                r_word_cnt <= r_word_cnt + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign cpu_reset_o = r_cpu_reset;
    assign busy        = w_busy;
    assign error       = r_error;

endmodule
`default_nettype wire
